// File: rtl/pixel_rgb_formatter_pkg.sv
// pixel_fmt_pkg: float32 constants, per-channel clamp record and tag sizing helpers
// shared by the pixel formatter, its tag FIFO and its bus interface.
package pixel_fmt_pkg;

  localparam logic [31:0] FLOAT_ONE       = 32'h3F800000;
  localparam int unsigned FLOAT_BIAS      = 127;
  localparam int unsigned FLOAT_MANT_BITS = 23;
  localparam int unsigned FLOAT_EXP_BITS  = 8;

  typedef enum logic [1:0] {
    CLAMP_ZERO = 2'd0,
    CLAMP_PASS = 2'd1,
    CLAMP_SAT  = 2'd2
  } clamp_e;

  // Clamped channel as carried from S1 to S2; a zeroed channel has exp == 0.
  typedef struct packed {
    logic                       sat;
    logic [FLOAT_EXP_BITS-1:0]  exp;
    logic [FLOAT_MANT_BITS-1:0] mant;
  } clamp_ch_t;

  // Width of a packed {x, y, block_visible, overlay} tag.
  function automatic int unsigned tag_bits(input int unsigned h_bits,
                                           input int unsigned v_bits,
                                           input int unsigned num_ovl);
    return h_bits + v_bits + 1 + num_ovl;
  endfunction

  // Negative, zero, denormal and NaN go to 0; anything >= 1.0 (incl. +inf) saturates.
  function automatic clamp_e clamp_class(input logic [31:0] f);
    logic [FLOAT_EXP_BITS-1:0] e;
    logic                      is_nan;
    e      = f[30:23];
    is_nan = (e == '1) && (f[FLOAT_MANT_BITS-1:0] != '0);
    if (f[31] || (e == '0) || is_nan) return CLAMP_ZERO;
    if (f[30:0] >= FLOAT_ONE[30:0])    return CLAMP_SAT;
    return CLAMP_PASS;
  endfunction

endpackage

// File: rtl/pixel_rgb_formatter_if.sv
// pixel_rgb_formatter_if: pixel issue/colour inputs, palette, error clear and the
// formatted pixel outputs. slave = formatter side, master = pipeline/consumer side.
interface pixel_rgb_formatter_if #(
  parameter int unsigned OUT_BITS     = 4,
  parameter int unsigned H_BITS       = 11,
  parameter int unsigned V_BITS       = 10,
  parameter int unsigned NUM_OVERLAYS = 2,
  parameter int unsigned TAG_DEPTH    = 512
);
  import pixel_fmt_pkg::*;

  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam int unsigned PAL_W = NUM_OVERLAYS * 3 * OUT_BITS;

  logic                    issue_valid_in;
  logic [H_BITS-1:0]       x_in;
  logic [V_BITS-1:0]       y_in;
  logic                    block_visible_in;
  logic [NUM_OVERLAYS-1:0] overlay_in;
  logic                    color_valid_in;
  logic [31:0]             r_in;
  logic [31:0]             g_in;
  logic [31:0]             b_in;
  logic [PAL_W-1:0]        overlay_color_in;
  logic                    clear_err_in;

  logic [H_BITS-1:0]       x_out;
  logic [V_BITS-1:0]       y_out;
  logic                    block_visible_out;
  logic [OUT_BITS-1:0]     r_out;
  logic [OUT_BITS-1:0]     g_out;
  logic [OUT_BITS-1:0]     b_out;
  logic                    rgb_valid;
  logic [CNT_W-1:0]        tag_count;
  logic                    tag_overflow;
  logic                    tag_underflow;

  modport master (
    output issue_valid_in, x_in, y_in, block_visible_in, overlay_in,
           color_valid_in, r_in, g_in, b_in, overlay_color_in, clear_err_in,
    input  x_out, y_out, block_visible_out, r_out, g_out, b_out, rgb_valid,
           tag_count, tag_overflow, tag_underflow
  );

  modport slave (
    input  issue_valid_in, x_in, y_in, block_visible_in, overlay_in,
           color_valid_in, r_in, g_in, b_in, overlay_color_in, clear_err_in,
    output x_out, y_out, block_visible_out, r_out, g_out, b_out, rgb_valid,
           tag_count, tag_overflow, tag_underflow
  );

endinterface

// File: rtl/pixel_rgb_formatter_tag_fifo.sv
// tag_fifo: single-clock FIFO with registered read data.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (valid the cycle
// after an accepted pop), full_c/empty_c (combinational from count), count.
// A pop while empty is ignored; a push while full is accepted only with a pop.
module tag_fifo
  import pixel_fmt_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full_c,
  output logic                    empty_c,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic [WIDTH-1:0] rdata_d, rdata_q;
  logic             do_push, do_pop;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_pop   = pop && !empty_c;
    do_push  = push && (!full_c || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    rdata_d  = do_pop ? mem[rd_ptr_q] : rdata_q;
  end

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign count = count_q;

endmodule

// File: rtl/pixel_rgb_formatter.sv
// pixel_rgb_formatter: clamps float32 RGB to [0,1], converts to OUT_BITS-bit
// integers and applies a prioritised overlay palette. Pixel sideband rides in a
// tag FIFO pushed at issue and popped when the matching colour arrives.
// Ports: clk_in, rst_n_in (async active-low), pix (slave modport: issue/colour
// inputs, palette, clear_err_in; registered pixel outputs, tag_count, sticky flags).
// Pipeline: S1 clamp + tag read, S2 float-to-fixed, S3 overlay mux into outputs.
module pixel_rgb_formatter
  import pixel_fmt_pkg::*;
#(
  parameter int unsigned OUT_BITS     = 4,
  parameter int unsigned H_BITS       = 11,
  parameter int unsigned V_BITS       = 10,
  parameter int unsigned NUM_OVERLAYS = 2,
  parameter int unsigned TAG_DEPTH    = 512
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  pixel_rgb_formatter_if.slave pix
);

  localparam int unsigned TAG_W = tag_bits(H_BITS, V_BITS, NUM_OVERLAYS);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam int unsigned SIG_W = FLOAT_MANT_BITS + 1;

  typedef struct packed {
    logic [H_BITS-1:0]       x;
    logic [V_BITS-1:0]       y;
    logic                    vis;
    logic [NUM_OVERLAYS-1:0] ovl;
  } pixel_tag_t;

  pixel_tag_t          push_tag, s1_tag;
  logic [TAG_W-1:0]    fifo_rdata;
  logic                fifo_full_c, fifo_empty_c;
  logic [CNT_W-1:0]    fifo_count;

  logic                s1_valid_d, s1_valid_q;
  logic                s2_valid_d, s2_valid_q;
  pixel_tag_t          s2_tag_d, s2_tag_q;
  logic                ovf_d, ovf_q, unf_d, unf_q;

  logic                rgb_valid_d, rgb_valid_q;
  logic [H_BITS-1:0]   x_out_d, x_out_q;
  logic [V_BITS-1:0]   y_out_d, y_out_q;
  logic                vis_out_d, vis_out_q;
  logic [OUT_BITS-1:0] r_out_d, r_out_q, g_out_d, g_out_q, b_out_d, b_out_q;
  logic                ovl_sel;

  logic [31:0]         chan_in [3];
  logic [OUT_BITS-1:0] conv [3];

  assign push_tag = '{x: pix.x_in, y: pix.y_in, vis: pix.block_visible_in, ovl: pix.overlay_in};
  assign s1_tag   = pixel_tag_t'(fifo_rdata);

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .push    (pix.issue_valid_in),
    .pop     (pix.color_valid_in),
    .wdata   (push_tag),
    .rdata   (fifo_rdata),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

  assign chan_in[0] = pix.r_in;
  assign chan_in[1] = pix.g_in;
  assign chan_in[2] = pix.b_in;

  // Per-channel clamp (S1) and float-to-fixed (S2).
  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    clamp_ch_t           s1_d, s1_q;
    logic [OUT_BITS-1:0] conv_d, conv_q;
    logic [8:0]          shift;
    logic [SIG_W-1:0]    sig;

    always_comb begin
      s1_d = '0;
      case (clamp_class(chan_in[ch]))
        CLAMP_SAT:  s1_d.sat = 1'b1;
        CLAMP_PASS: begin
          s1_d.exp  = chan_in[ch][30:23];
          s1_d.mant = chan_in[ch][FLOAT_MANT_BITS-1:0];
        end
        default: ;
      endcase
    end

    // floor(v * 2^OUT_BITS) = {1,mant} >> (bias + mant_bits - exp - OUT_BITS).
    // Zeroed channels carry exp 0, which always lands in the shift >= 24 branch.
    always_comb begin
      shift  = 9'(FLOAT_BIAS + FLOAT_MANT_BITS - OUT_BITS) - {1'b0, s1_q.exp};
      sig    = {1'b1, s1_q.mant};
      conv_d = '0;
      if (s1_q.sat)                  conv_d = '1;
      else if (shift < 9'(SIG_W))    conv_d = OUT_BITS'(sig >> shift);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        s1_q   <= '0;
        conv_q <= '0;
      end else begin
        s1_q   <= s1_d;
        conv_q <= conv_d;
      end
    end

    assign conv[ch] = conv_q;
  end

  // Stage valids, tag alignment and sticky error flags (clear loses to a new error).
  always_comb begin
    s1_valid_d = pix.color_valid_in && !fifo_empty_c;
    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (pix.clear_err_in) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (pix.issue_valid_in && fifo_full_c && !pix.color_valid_in) ovf_d = 1'b1;
    if (pix.color_valid_in && fifo_empty_c)                      unf_d = 1'b1;
  end

  // S3: lowest-index active overlay replaces the colour and forces visibility.
  always_comb begin
    rgb_valid_d = s2_valid_q;
    x_out_d     = s2_tag_q.x;
    y_out_d     = s2_tag_q.y;
    vis_out_d   = s2_tag_q.vis;
    r_out_d     = conv[0];
    g_out_d     = conv[1];
    b_out_d     = conv[2];
    ovl_sel     = 1'b0;
    for (int unsigned k = 0; k < NUM_OVERLAYS; k++) begin
      if (!ovl_sel && s2_tag_q.ovl[k]) begin
        ovl_sel   = 1'b1;
        vis_out_d = 1'b1;
        {r_out_d, g_out_d, b_out_d} = pix.overlay_color_in[k*3*OUT_BITS +: 3*OUT_BITS];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      rgb_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      vis_out_q   <= 1'b0;
      r_out_q     <= '0;
      g_out_q     <= '0;
      b_out_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      rgb_valid_q <= rgb_valid_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      vis_out_q   <= vis_out_d;
      r_out_q     <= r_out_d;
      g_out_q     <= g_out_d;
      b_out_q     <= b_out_d;
    end
  end

  assign pix.rgb_valid         = rgb_valid_q;
  assign pix.x_out             = x_out_q;
  assign pix.y_out             = y_out_q;
  assign pix.block_visible_out = vis_out_q;
  assign pix.r_out             = r_out_q;
  assign pix.g_out             = g_out_q;
  assign pix.b_out             = b_out_q;
  assign pix.tag_count         = fifo_count;
  assign pix.tag_overflow      = ovf_q;
  assign pix.tag_underflow     = unf_q;

endmodule
